// File: rtl/encode_64b_67b_pkg.sv
// Shared widths, header codes and bit positions for the 64B/67B TX encoder.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package encode_64b_67b_pkg;

    localparam int BLOCK_W   = 67;
    localparam int PAYLOAD_W = 64;
    localparam int TXWORD_W  = 80;
    localparam int GB_W      = 160;
    localparam int RD_W      = 9;
    localparam int FILL_W    = 8;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam int INV_BIT = 66;
    localparam int HDR_HI  = 65;
    localparam int HDR_LO  = 64;

    // Only 01 and 10 are legal framing headers.
    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/encode_64b_67b_disparity.sv
// Chooses plain or inverted 67-bit block from running disparity; returns block and its disparity.
// Latency: purely combinational.
// Backpressure: none.
module disparity_64b_67b
    import encode_64b_67b_pkg::*;
(
    input  logic [PAYLOAD_W-1:0]   data_in,
    input  logic [1:0]             header_in,
    input  logic signed [RD_W-1:0] rd,
    input  logic                   passthrough,
    output logic [BLOCK_W-1:0]     block,
    output logic signed [RD_W-1:0] disp
);

    logic [6:0] ones_data;
    logic [6:0] ones_hdr;
    logic [6:0] ones_blk;
    logic       dp_neg;
    logic       invert;

    // Popcount the candidate block, decide inversion, and derive the chosen block's disparity.
    always_comb begin
        ones_data = '0;
        for (int i = 0; i < PAYLOAD_W; i++) begin
            ones_data = ones_data + {6'b0, data_in[i]};
        end
        ones_hdr = {6'b0, header_in[1]} + {6'b0, header_in[0]};
        // 2*pop - 67 is negative exactly when pop <= 33.
        dp_neg   = (ones_data + ones_hdr) <= 7'd33;
        invert   = !passthrough && (rd != '0) && (rd[RD_W-1] == dp_neg);
        ones_blk = invert ? (7'd1 + ones_hdr + (7'd64 - ones_data))
                          : (ones_hdr + ones_data);
        block    = invert ? {1'b1, header_in, ~data_in} : {1'b0, header_in, data_in};
        disp     = $signed({1'b0, ones_blk, 1'b0}) - 9'sd67;
    end

endmodule

// File: rtl/encode_64b_67b.sv
// 64B/67B disparity encoder feeding a 160-bit gearbox that emits 80-bit words LSB-first.
// Latency: block bits appear on DATA_OUT at the first emit after they sit below bit 80; all outputs registered.
// Backpressure: none; input always accepted, output has bubbles when fewer than 80 bits are buffered.
module encode_64b_67b
    import encode_64b_67b_pkg::*;
(
    input  logic                  USER_CLK,
    input  logic                  SYSTEM_RESET_N,
    input  logic [PAYLOAD_W-1:0]  DATA_IN,
    input  logic [1:0]            HEADER_IN,
    input  logic                  DATA_VALID_IN,
    input  logic                  PASSTHROUGH,
    output logic [TXWORD_W-1:0]   DATA_OUT,
    output logic                  DATA_VALID_OUT,
    output logic                  HEADER_ERR
);

    localparam logic signed [RD_W:0]   SUM_MAX = 10'sd255;
    localparam logic signed [RD_W:0]   SUM_MIN = -10'sd256;
    localparam logic signed [RD_W-1:0] RD_MAX  = 9'sd255;
    localparam logic signed [RD_W-1:0] RD_MIN  = 9'b1_0000_0000;

    logic signed [RD_W-1:0] rd_q, rd_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [GB_W-1:0]        buf_q, buf_d;
    logic [TXWORD_W-1:0]    data_out_q, data_out_d;
    logic                   data_valid_out_q, data_valid_out_d;
    logic                   header_err_q, header_err_d;

    logic [BLOCK_W-1:0]     block;
    logic signed [RD_W-1:0] disp;
    logic signed [RD_W:0]   rd_sum;
    logic signed [RD_W-1:0] rd_next;
    logic                   emit;
    logic [FILL_W-1:0]      base;
    logic [GB_W-1:0]        buf_shift;

    disparity_64b_67b u_disparity (
        .data_in     (DATA_IN),
        .header_in   (HEADER_IN),
        .rd          (rd_q),
        .passthrough (PASSTHROUGH),
        .block       (block),
        .disp        (disp)
    );

    // Next-state for running disparity, gearbox buffer/fill and the registered outputs.
    always_comb begin
        rd_sum = $signed({rd_q[RD_W-1], rd_q}) + $signed({disp[RD_W-1], disp});
        if (rd_sum > SUM_MAX) begin
            rd_next = RD_MAX;
        end else if (rd_sum < SUM_MIN) begin
            rd_next = RD_MIN;
        end else begin
            rd_next = rd_sum[RD_W-1:0];
        end
        rd_d = PASSTHROUGH ? '0 : (DATA_VALID_IN ? rd_next : rd_q);

        // Emit decision uses the pre-edge fill; the new block lands after the shift.
        emit      = fill_q >= 8'd80;
        base      = emit ? (fill_q - 8'd80) : fill_q;
        buf_shift = emit ? {{TXWORD_W{1'b0}}, buf_q[GB_W-1:TXWORD_W]} : buf_q;
        buf_d     = buf_shift;
        if (DATA_VALID_IN) begin
            buf_d = buf_shift | ({{(GB_W-BLOCK_W){1'b0}}, block} << base);
        end
        // base <= 79 and base + 67 <= 146 whenever a block is added, so no clamp is needed.
        fill_d = base + (DATA_VALID_IN ? 8'd67 : 8'd0);

        data_out_d       = emit ? buf_q[TXWORD_W-1:0] : data_out_q;
        data_valid_out_d = emit;
        header_err_d     = DATA_VALID_IN && !hdr_is_valid(HEADER_IN);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            rd_q             <= '0;
            fill_q           <= '0;
            buf_q            <= '0;
            data_out_q       <= '0;
            data_valid_out_q <= 1'b0;
            header_err_q     <= 1'b0;
        end else begin
            rd_q             <= rd_d;
            fill_q           <= fill_d;
            buf_q            <= buf_d;
            data_out_q       <= data_out_d;
            data_valid_out_q <= data_valid_out_d;
            header_err_q     <= header_err_d;
        end
    end

    assign DATA_OUT       = data_out_q;
    assign DATA_VALID_OUT = data_valid_out_q;
    assign HEADER_ERR     = header_err_q;

endmodule

// File: tb/tb_encode_64b_67b.sv
// Directed bench for the 64B/67B encoder plus gearbox, with a bit-stream reference model.
// Latency: checks each output one time unit after the clock edge.
// Backpressure: none exercised; input is driven freely.
module tb_encode_64b_67b;

    logic        USER_CLK;
    logic        SYSTEM_RESET_N;
    logic [63:0] DATA_IN;
    logic [1:0]  HEADER_IN;
    logic        DATA_VALID_IN;
    logic        PASSTHROUGH;
    logic [79:0] DATA_OUT;
    logic        DATA_VALID_OUT;
    logic        HEADER_ERR;

    encode_64b_67b dut (
        .USER_CLK       (USER_CLK),
        .SYSTEM_RESET_N (SYSTEM_RESET_N),
        .DATA_IN        (DATA_IN),
        .HEADER_IN      (HEADER_IN),
        .DATA_VALID_IN  (DATA_VALID_IN),
        .PASSTHROUGH    (PASSTHROUGH),
        .DATA_OUT       (DATA_OUT),
        .DATA_VALID_OUT (DATA_VALID_OUT),
        .HEADER_ERR     (HEADER_ERR)
    );

    initial USER_CLK = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int vcount  = 0;

    // Reference model state
    int          m_rd   = 0;
    int          m_fill = 0;
    bit          m_q[$];
    logic [79:0] exp_word = '0;
    logic        exp_vld  = 1'b0;
    logic        exp_err  = 1'b0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rd     = 0;
        m_fill   = 0;
        m_q.delete();
        exp_word = '0;
        exp_vld  = 1'b0;
        exp_err  = 1'b0;
    endtask

    // One clock edge of the reference: emit from pre-edge fill, then append the accepted block.
    task automatic model_edge(input logic v, input logic [1:0] h, input logic [63:0] d, input logic pt);
        int          dp;
        int          s;
        logic        inv;
        logic [66:0] blk;
        exp_vld = (m_fill >= 80);
        if (exp_vld) begin
            for (int i = 0; i < 80; i++) exp_word[i] = m_q.pop_front();
        end
        if (v) begin
            dp  = 2 * $countones({h, d}) - 67;
            inv = !pt && (m_rd != 0) && ((m_rd < 0) == (dp < 0));
            blk = inv ? {1'b1, h, ~d} : {1'b0, h, d};
            s   = m_rd + 2 * $countones(blk) - 67;
            if (s > 255) s = 255;
            else if (s < -256) s = -256;
            m_rd = s;
            for (int i = 0; i < 67; i++) m_q.push_back(blk[i]);
        end
        if (pt) m_rd = 0;
        m_fill  = m_fill - (exp_vld ? 80 : 0) + (v ? 67 : 0);
        exp_err = v && ((h == 2'b00) || (h == 2'b11));
    endtask

    task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d, input logic pt);
        DATA_VALID_IN = v;
        HEADER_IN     = h;
        DATA_IN       = d;
        PASSTHROUGH   = pt;
        @(posedge USER_CLK);
        model_edge(v, h, d, pt);
        #1;
        if (DATA_VALID_OUT) vcount++;
        chk("data_valid_out", DATA_VALID_OUT, exp_vld);
        chk("data_out", DATA_OUT, exp_word);
        chk("header_err", HEADER_ERR, exp_err);
        chk_int("rd", int'($signed(dut.rd_q)), m_rd);
        chk_int("fill", int'(dut.fill_q), m_fill);
        chk_int("fill_le_146", int'(dut.fill_q <= 8'd146), 1);
    endtask

    logic [2:0] vpat;

    initial begin
        SYSTEM_RESET_N = 1'b0;
        DATA_IN        = '0;
        HEADER_IN      = 2'b01;
        DATA_VALID_IN  = 1'b0;
        PASSTHROUGH    = 1'b0;
        model_reset();
        repeat (2) @(posedge USER_CLK);
        #1;
        chk("rst_data_out", DATA_OUT, 80'h0);
        chk("rst_valid", DATA_VALID_OUT, 1'b0);
        chk("rst_err", HEADER_ERR, 1'b0);
        chk_int("rst_rd", int'($signed(dut.rd_q)), 0);
        chk_int("rst_fill", int'(dut.fill_q), 0);
        SYSTEM_RESET_N = 1'b1;

        // Two all-zero data blocks: second one must invert and bring RD back to 0.
        vcount = 0;
        step(1'b1, 2'b01, 64'h0, 1'b0);
        vpat[0] = DATA_VALID_OUT;
        chk_int("blk0_rd", int'($signed(dut.rd_q)), -65);
        step(1'b1, 2'b01, 64'h0, 1'b0);
        vpat[1] = DATA_VALID_OUT;
        chk_int("blk1_rd", int'($signed(dut.rd_q)), 0);
        step(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b0);
        vpat[2] = DATA_VALID_OUT;
        chk("valid_pattern", {77'h0, vpat}, 80'h4);
        chk("first_word", DATA_OUT, 80'hFFF9_0000_0000_0000_0000);
        for (int i = 3; i < 80; i++) begin
            step(1'b1, (i % 3 == 0) ? 2'b10 : 2'b01,
                 {32'(i * 32'h9E37_79B9), 32'(~(i * 32'h85EB_CA6B))}, 1'b0);
        end
        chk_int("valids_in_80_accepts", vcount, 66);
        step(1'b0, 2'b01, 64'h0, 1'b0);
        chk_int("valids_after_flush", vcount, 67);
        chk_int("fill_after_flush", int'(dut.fill_q), 0);

        // Passthrough with all-ones data: never inverted, RD pinned to zero.
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step(1'b0, 2'b01, 64'h0, 1'b0);
        chk_int("pt_rd_after", int'($signed(dut.rd_q)), 0);
        step(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk_int("post_pt_rd", int'($signed(dut.rd_q)), 63);

        // Single invalid header: still encoded, one-cycle error pulse.
        step(1'b1, 2'b11, 64'h0, 1'b0);
        chk("err_pulse_hi", HEADER_ERR, 1'b1);
        chk_int("err_rd", int'($signed(dut.rd_q)), 0);
        step(1'b0, 2'b01, 64'h0, 1'b0);
        chk("err_pulse_lo", HEADER_ERR, 1'b0);

        // Repeated invalid headers with 32 payload ones grow RD by +1 then +3 until saturating.
        for (int i = 0; i < 90; i++) step(1'b1, 2'b11, 64'h0000_0000_FFFF_FFFF, 1'b0);
        chk_int("rd_saturated", int'($signed(dut.rd_q)), 255);

        // Gapped input, then drain.
        for (int i = 0; i < 24; i++) begin
            step(i[0], (i % 4 == 1) ? 2'b10 : 2'b01, {32'(i * 32'h1234_5677), 32'(i * 32'h0BAD_F00D)}, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 64'h0, 1'b0);
        chk_int("drain_fill_lt80", int'(dut.fill_q < 8'd80), 1);
        chk("drain_valid_low", DATA_VALID_OUT, 1'b0);

        // Reset in the middle of a partially packed word.
        step(1'b1, 2'b01, 64'hDEAD_BEEF_0000_FFFF, 1'b0);
        step(1'b1, 2'b10, 64'h5555_AAAA_5555_AAAA, 1'b0);
        #2;
        SYSTEM_RESET_N = 1'b0;
        #1;
        model_reset();
        chk("midrst_data_out", DATA_OUT, 80'h0);
        chk("midrst_valid", DATA_VALID_OUT, 1'b0);
        chk("midrst_err", HEADER_ERR, 1'b0);
        chk_int("midrst_fill", int'(dut.fill_q), 0);
        #1;
        SYSTEM_RESET_N = 1'b1;
        step(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0);
        step(1'b1, 2'b01, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        step(1'b1, 2'b01, 64'h0, 1'b0);
        chk("rst_first_blk", {13'h0, DATA_OUT[66:0]}, {13'h0, 67'h2_0123_4567_89AB_CDEF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encode_64b_67b.md
# encode_64B_67B

Transmit-side Interlaken 64B/67B encoder and TX gearbox. It accepts 64-bit words with a 2-bit framing header, applies running-disparity inversion to form 67-bit blocks, and packs those blocks LSB-first into 80-bit transceiver words. It sits between the TX framing/scrambler logic and the transceiver TX data port. It is the transmit counterpart of the lane decoder: bit 66 is the inversion flag, bits 65:64 are the header, bits 63:0 are the payload.

## Interface
Parameters:
- none; all widths are fixed constants from the shared package.

Ports:
- USER_CLK  in  1  single clock for all logic.
- SYSTEM_RESET_N  in  1  asynchronous, active-low reset.
- DATA_IN  in  64  payload word, not yet inverted.
- HEADER_IN  in  2  framing header; 2'b01 means data, 2'b10 means control.
- DATA_VALID_IN  in  1  DATA_IN/HEADER_IN hold a block to encode. The block is always accepted; there is no backpressure.
- PASSTHROUGH  in  1  disables disparity inversion.
- DATA_OUT  out  80  gearboxed transceiver word; bit 0 is transmitted first.
- DATA_VALID_OUT  out  1  DATA_OUT holds a new word.
- HEADER_ERR  out  1  one-cycle pulse when an accepted block has header 2'b00 or 2'b11.

## Operation
Disparity encoding is combinational in the accept cycle, with registered state:
- Dp = 2*popcount({1'b0, HEADER_IN, DATA_IN}) - 67. Dp is odd and never 0.
- RD is the running disparity: 9-bit signed, reset 0.
- Invert when RD != 0 and sign(RD) == sign(Dp). An inverted block is {1'b1, HEADER_IN, ~DATA_IN}; otherwise the block is {1'b0, HEADER_IN, DATA_IN}.
- RD_next = RD + disparity of the chosen 67-bit block. RD saturates at +255 / -256.
- With valid headers |RD| never exceeds 67. Saturation only matters for invalid headers.
- When PASSTHROUGH=1: never invert (bit 66 = 0), and RD is forced to 0 at each edge.
- An invalid header is still encoded and transmitted unchanged. HEADER_ERR asserts on the following cycle.

Gearbox:
- Buffer is 160 bits; fill counter runs 0..146 and resets to 0.
- Valid bits occupy buf[fill-1:0].
- Emit when pre-edge fill >= 80: DATA_OUT <= buf[79:0], DATA_VALID_OUT <= 1, and the buffer shifts right by 80. Otherwise DATA_VALID_OUT <= 0 and DATA_OUT holds its previous value.
- Accept writes the 67-bit block at bit offset (fill - 80*emit).
- fill_next = fill - 80*emit + 67*accept, with maximum 146. Overflow is impossible, which is why there is no ready signal.
- Emit and accept in the same cycle are both performed.
- Output bubbles are expected. Over any 80 consecutive accepted blocks, exactly 67 words are emitted (±1).

Reset:
- Async assert clears DATA_OUT=0, DATA_VALID_OUT=0, HEADER_ERR=0, RD=0, fill=0 and the buffer.
- Reset mid-stream discards partially packed bits.
- The first accept after release is placed at bit 0.

## Timing
- Accept at edge k: the block's RD effect is visible at edge k.
- Bit 0 of a block reaches DATA_OUT at the first emitting edge after the block's offset is below 80.
- From reset with continuous input, the first DATA_VALID_OUT=1 follows the third accept edge (fill 0→67→134, emit).
- HEADER_ERR latency is 1 cycle. All outputs are registered.
- A PASSTHROUGH change takes effect on the block accepted at the same edge.

## Structure
- The shared package carries:
  - BLOCK_W=67, PAYLOAD_W=64, TXWORD_W=80, GB_W=160, RD_W=9;
  - HDR_DATA=2'b01, HDR_CTRL=2'b10;
  - bit-position constants INV_BIT=66, HDR_HI=65, HDR_LO=64.
- One sub-module, disparity_64B_67B, is purely combinational. It takes DATA_IN, HEADER_IN, RD and PASSTHROUGH and returns the 67-bit block and the chosen disparity.
- RD, the fill counter and the buffer live in encode_64B_67B.

## Test plan
- Reset, then HEADER_IN=01, DATA_IN=0 for two cycles:
  - block0 = {0, 01, 64'h0} with RD -65;
  - block1 = {1, 01, 64'hFFFF_FFFF_FFFF_FFFF} with RD 0.
- Continuous valid input from reset:
  - DATA_VALID_OUT pattern is 0, 0, 1, ...;
  - first word = {block1[12:0], block0[66:0]};
  - 67 valids per 80 accepts, and fill never exceeds 146.
- PASSTHROUGH=1 with all-ones data: bit 66 is always 0, no inversion, and RD reads 0 after deassert.
- HEADER_IN=2'b11 on one block: HEADER_ERR is high for exactly one cycle, the block is still packed, and RD stays in range. Repeated invalid headers saturate RD at +255 with no wrap.
- Gapped input (DATA_VALID_IN toggling): packed bits remain contiguous with no gap bits, and the buffer drains to fill < 80 then DATA_VALID_OUT=0.
- Assert SYSTEM_RESET_N low mid-word: all outputs are 0 immediately, and after release the first accepted block lands at DATA_OUT[66:0].
